// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ULA codes and mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ULA    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
`ifdef MULTICYCLE_JAL_EN
      OP_JAL:  sel = IMM_J;
`endif
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ula_decoder.sv
// Combinational ULA control decode from ALUOp and instruction funct fields.
module ula_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ula_control
);

  always_comb begin
    ula_control = ULA_ADD;
    case (alu_op)
      ALUOP_SUB: ula_control = ULA_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type from I-type so addi with imm[10]=1 stays add
          3'b000:  ula_control = (op5 && funct7b5) ? ULA_SUB : ULA_ADD;
          3'b010:  ula_control = ULA_SLT;
          3'b110:  ula_control = ULA_OR;
          3'b111:  ula_control = ULA_AND;
          default: ula_control = ULA_ADD;
        endcase
      end
      default: ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit RISC-V datapath; jal support enabled by MULTICYCLE_JAL_EN.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [2:0] ula_control,
  output logic [1:0] ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  state_t  state, next_state;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // rst forces every enable and select low combinationally so an aborted write drops at once
  always_comb begin
    next_state = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    ula_src_a  = SRCA_PC;
    ula_src_b  = SRCB_RD2;
    imm_src    = IMM_I;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      imm_src = imm_sel(op);
      case (state)
        S_FETCH: begin
          ula_src_b  = SRCB_FOUR;
          result_src = RES_ULA;
          ir_write   = mem_ready;
          pc_update  = mem_ready;
          if (mem_ready) next_state = S_DECODE;
        end
        S_DECODE: begin
          ula_src_a = SRCA_OLDPC;
          ula_src_b = SRCB_IMM;
          case (op)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = S_EXECR;
            OP_I:         next_state = S_EXECI;
            OP_BEQ:       next_state = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:       next_state = S_JAL;
`endif
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ula_src_a  = SRCA_RD1;
          ula_src_b  = SRCB_IMM;
          next_state = (op == OP_SW) ? S_MEMWR : S_MEMREAD;
        end
        S_MEMREAD: begin
          adr_src = 1'b1;
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          adr_src    = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) next_state = S_FETCH;
        end
        S_EXECR: begin
          ula_src_a  = SRCA_RD1;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_EXECI: begin
          ula_src_a  = SRCA_RD1;
          ula_src_b  = SRCB_IMM;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_BEQ: begin
          ula_src_a  = SRCA_RD1;
          alu_op     = ALUOP_SUB;
          branch     = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
`ifdef MULTICYCLE_JAL_EN
        S_JAL: begin
          ula_src_a  = SRCA_OLDPC;
          ula_src_b  = SRCB_FOUR;
          pc_update  = 1'b1;
          next_state = S_ALUWB;
        end
`endif
        default: next_state = S_FETCH;
      endcase
    end
  end

  assign pc_write = pc_update | (branch & zero);

  ula_decoder u_ula_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .ula_control (ula_control)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: per-cycle expected output vectors from a spec-level table.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0000000;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, ula_src_a, ula_src_b, imm_src;
  logic [2:0] ula_control;
  logic       reg_write, instr_done, illegal;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .ula_control (ula_control),
    .ula_src_a   (ula_src_a),
    .ula_src_b   (ula_src_b),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  typedef enum {P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWR,
                P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL} phase_t;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [17:0] dut_vec;
  assign dut_vec = {pc_write, adr_src, mem_write, ir_write, result_src, ula_control,
                    ula_src_a, ula_src_b, imm_src, reg_write, instr_done, illegal};

  function automatic logic [17:0] model(input phase_t ph, input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic mr, input logic z);
    logic       pw, as, mw, irw, rw, dn, il;
    logic [1:0] rs, sa, sb, im;
    logic [2:0] uc, fu;
    logic       legal;
    pw = 0; as = 0; mw = 0; irw = 0; rw = 0; dn = 0; il = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; uc = 3'b000;
    if (o == 7'b0100011)      im = 2'b01;
    else if (o == 7'b1100011) im = 2'b10;
`ifdef MULTICYCLE_JAL_EN
    else if (o == 7'b1101111) im = 2'b11;
`endif
    else                      im = 2'b00;
    case (f3)
      3'b000:  fu = (ph == P_EXECR && f7) ? 3'b001 : 3'b000;
      3'b010:  fu = 3'b101;
      3'b110:  fu = 3'b011;
      3'b111:  fu = 3'b010;
      default: fu = 3'b000;
    endcase
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011);
`ifdef MULTICYCLE_JAL_EN
    legal = legal || (o == 7'b1101111);
`endif
    case (ph)
      P_RST:     im = 2'b00;
      P_FETCH:   begin sb = 2'b10; rs = 2'b10; irw = mr; pw = mr; end
      P_DECODE:  begin sa = 2'b01; sb = 2'b01; il = !legal; dn = !legal; end
      P_MEMADR:  begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD: as = 1;
      P_MEMWB:   begin rs = 2'b01; rw = 1; dn = 1; end
      P_MEMWR:   begin as = 1; mw = 1; dn = mr; end
      P_EXECR:   begin sa = 2'b10; uc = fu; end
      P_EXECI:   begin sa = 2'b10; sb = 2'b01; uc = fu; end
      P_ALUWB:   begin rw = 1; dn = 1; end
      P_BEQ:     begin sa = 2'b10; uc = 3'b001; pw = z; dn = 1; end
      P_JAL:     begin sa = 2'b01; sb = 2'b10; pw = 1; end
      default:   ;
    endcase
    return {pw, as, mw, irw, rs, uc, sa, sb, im, rw, dn, il};
  endfunction

  task automatic step(input phase_t ph, input logic mr, input logic z, input logic r, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = z;
    rst       = r;
    exp_q.push_back('{tag, model(ph, op, funct3, funct7b5, mr, z)});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    assert (dut_vec === e.v) n_pass++;
    else $error("FAIL %s: observed %05h expected %05h", e.tag, dut_vec, e.v);
  endtask

  task automatic load(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7, input string tag);
    load(o, f3, f7);
    step(P_FETCH, 1, 0, 0, {tag, "_fetch"});
    step(P_DECODE, 1, 1, 0, {tag, "_decode"});
    step((o == 7'b0110011) ? P_EXECR : P_EXECI, 1, 1, 0, {tag, "_exec"});
    step(P_ALUWB, 1, 1, 0, {tag, "_wb"});
  endtask

  initial begin
    step(P_RST, 1, 1, 1, "reset0");
    step(P_RST, 0, 0, 1, "reset1");

    run_alu(7'b0110011, 3'b000, 1'b0, "add");
    run_alu(7'b0110011, 3'b000, 1'b1, "sub");
    run_alu(7'b0110011, 3'b010, 1'b0, "slt");
    run_alu(7'b0110011, 3'b111, 1'b0, "and");
    run_alu(7'b0110011, 3'b110, 1'b0, "or");
    run_alu(7'b0110011, 3'b100, 1'b0, "xor_as_add");
    run_alu(7'b0010011, 3'b000, 1'b1, "addi_f7");
    run_alu(7'b0010011, 3'b111, 1'b0, "andi");

    load(7'b0000011, 3'b010, 1'b0);
    step(P_FETCH, 0, 1, 0, "lw_fetch_stall");
    step(P_FETCH, 1, 0, 0, "lw_fetch");
    step(P_DECODE, 1, 0, 0, "lw_decode");
    step(P_MEMADR, 1, 0, 0, "lw_memadr");
    for (int unsigned i = 0; i < 3; i++) step(P_MEMREAD, 0, 1, 0, "lw_memread_wait");
    step(P_MEMREAD, 1, 0, 0, "lw_memread");
    step(P_MEMWB, 0, 1, 0, "lw_memwb");

    load(7'b0100011, 3'b010, 1'b0);
    step(P_FETCH, 1, 0, 0, "sw_fetch");
    step(P_DECODE, 1, 0, 0, "sw_decode");
    step(P_MEMADR, 1, 0, 0, "sw_memadr");
    step(P_MEMWR, 0, 1, 0, "sw_memwr_wait0");
    step(P_MEMWR, 0, 0, 0, "sw_memwr_wait1");
    step(P_MEMWR, 1, 0, 0, "sw_memwr_done");

    load(7'b1100011, 3'b000, 1'b0);
    step(P_FETCH, 1, 0, 0, "beq_t_fetch");
    step(P_DECODE, 1, 1, 0, "beq_t_decode");
    step(P_BEQ, 1, 1, 0, "beq_taken");
    step(P_FETCH, 1, 0, 0, "beq_n_fetch");
    step(P_DECODE, 1, 0, 0, "beq_n_decode");
    step(P_BEQ, 1, 0, 0, "beq_not_taken");

    load(7'b1111111, 3'b000, 1'b0);
    step(P_FETCH, 1, 0, 0, "ill_fetch");
    step(P_DECODE, 1, 0, 0, "ill_decode");
    step(P_FETCH, 0, 0, 0, "ill_back_to_fetch");
    step(P_FETCH, 1, 0, 0, "ill_fetch2");

    load(7'b1101111, 3'b000, 1'b0);
    step(P_DECODE, 1, 0, 0, "jal_decode");
`ifdef MULTICYCLE_JAL_EN
    step(P_JAL, 1, 0, 0, "jal_state");
    step(P_ALUWB, 1, 0, 0, "jal_wb");
`endif
    step(P_FETCH, 0, 0, 0, "jal_after");

    load(7'b0100011, 3'b010, 1'b0);
    step(P_FETCH, 1, 0, 0, "rst_sw_fetch");
    step(P_DECODE, 1, 0, 0, "rst_sw_decode");
    step(P_MEMADR, 1, 0, 0, "rst_sw_memadr");
    step(P_MEMWR, 0, 0, 0, "rst_sw_memwr");
    step(P_RST, 0, 0, 1, "rst_in_memwr");
    for (int unsigned i = 0; i < 4; i++) step(P_FETCH, 0, 1, 0, "fetch_stall_after_rst");

    load(7'b0000011, 3'b010, 1'b0);
    step(P_FETCH, 1, 0, 0, "rst_lw_fetch");
    step(P_DECODE, 1, 0, 0, "rst_lw_decode");
    step(P_MEMADR, 1, 0, 0, "rst_lw_memadr");
    step(P_MEMREAD, 0, 0, 0, "rst_lw_memread");
    step(P_RST, 1, 0, 1, "rst_in_memread");
    step(P_FETCH, 1, 0, 0, "fetch_after_rst2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
